instruction_loader: RTL
=======================

# instruction_loader

Sequencing controller that fills the pipeline's instruction memory from a byte stream (UART receiver side of the debug unit). It assembles incoming bytes into 32-bit instruction words, writes them to consecutive word addresses starting at 0, and stops on a halt instruction or on memory overflow. While loading it gates instruction fetch off; afterwards it hands the memory back to the pipeline.

## Interface

Parameters:
- PC_WIDTH, 9, word-address width of instruction memory; DEPTH = 2**PC_WIDTH words
- NB_WIDTH, 32, instruction width; fixed at 4 × NB_BYTE
- NB_BYTE, 8, stream byte width
- HALT_INSTR, 32'hFFFF_FFFF, word that terminates a load

Ports:
- i_clk  in  1  single clock; all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  one-cycle pulse; begins a load (honoured in IDLE, DONE, ERROR only)
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid this cycle
- o_imem_write_enable  out  1  one-cycle write pulse to instruction memory
- o_imem_address  out  PC_WIDTH  write address (word index)
- o_imem_write_data  out  NB_WIDTH  assembled instruction
- o_imem_read_enable  out  1  fetch permission for pipeline
- o_busy  out  1  high in LOAD and FINISH
- o_load_done  out  1  high in DONE
- o_overflow  out  1  high in ERROR
- o_word_count  out  PC_WIDTH+1  words written in current/last load

## Operation

- States: IDLE, LOAD, FINISH, DONE, ERROR.
- IDLE: i_rx_valid ignored. i_start → LOAD; clear byte counter, shift register, address, word count.
- LOAD: each i_rx_valid accepts one byte; byte counter 0..3, wraps. Big-endian: first byte → bits [31:24], fourth → [7:0].
  - On fourth byte: o_imem_write_data <= {shift[23:0], i_rx_data}; write pulse registered; shift register and byte counter cleared in the same edge, so a byte arriving in the write cycle is byte 0 of the next word.
  - Address and word count increment at the edge ending the write pulse.
  - Fourth byte completes HALT_INSTR → FINISH (halt word is written).
  - Fourth byte completes a non-halt word at address DEPTH-1 → ERROR (word is written; address does not wrap, holds DEPTH-1).
  - i_start ignored.
- FINISH: one cycle, carries the halt write pulse; i_rx_valid ignored; → DONE.
- DONE: rx ignored; i_start → LOAD (fresh load, counts cleared).
- ERROR: rx ignored; o_word_count = DEPTH; i_start → LOAD.
- o_imem_read_enable = (state is IDLE or DONE) and not o_imem_write_enable; 0 in LOAD, FINISH, ERROR.
- o_word_count counts words including halt; saturates at DEPTH.

## Timing

- Reset (i_reset low at an edge): state IDLE; o_imem_write_enable 0, o_imem_address 0, o_imem_write_data 0, o_busy 0, o_load_done 0, o_overflow 0, o_word_count 0; o_imem_read_enable 1. Mid-load reset discards partial bytes, kills a pending write pulse; memory contents untouched.
- Fourth byte accepted at edge n → o_imem_write_enable high for exactly cycle n..n+1, address/data stable throughout; address increments at edge n+1.
- Halt word at edge n → FINISH during cycle after n; o_load_done and o_imem_read_enable high from edge n+1 onward (first cycle with write pulse low).
- Overflow word at edge n → o_overflow high from edge n; write still performed in that cycle.
- i_start and i_rx_valid same cycle in IDLE: start taken, byte dropped.
- Back-to-back strobes (every cycle) sustained without loss: max rate 1 byte/cycle.

## Test plan

- Reset release, no stimulus → read_enable 1, all other outputs 0, state IDLE; rx bytes in IDLE produce no write.
- i_start, bytes 12 34 56 78, AA BB CC DD, FF FF FF FF → writes 0x12345678 @0, 0xAABBCCDD @1, 0xFFFFFFFF @2; load_done 1 one cycle after last pulse, word_count 3; memory readback matches.
- Same stream with i_rx_valid high every cycle → identical writes, no dropped byte at word boundaries.
- Stream 512 non-halt words (PC_WIDTH=9) → 512 writes, last @511, overflow 1, word_count 512, read_enable 0; then i_start restarts at address 0.
- Reset after 2 bytes of word 1, then i_start and 4 fresh bytes 01 02 03 04 → single write 0x01020304 @0; stale bytes absent.
- i_start during LOAD and rx in DONE → ignored: address, count, memory unchanged.

Source files
------------

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write/fetch bus of the instruction loader.
// The loader drives the memory side (master); the environment drives the byte stream (slave).
interface instruction_loader_if #(
    parameter int unsigned PC_WIDTH = 9,
    parameter int unsigned NB_WIDTH = 32,
    parameter int unsigned NB_BYTE  = 8
);
    logic [NB_BYTE-1:0]  i_rx_data;
    logic                i_rx_valid;
    logic                o_imem_write_enable;
    logic [PC_WIDTH-1:0] o_imem_address;
    logic [NB_WIDTH-1:0] o_imem_write_data;
    logic                o_imem_read_enable;

    modport master (
        input  i_rx_data,
        input  i_rx_valid,
        output o_imem_write_enable,
        output o_imem_address,
        output o_imem_write_data,
        output o_imem_read_enable
    );

    modport slave (
        output i_rx_data,
        output i_rx_valid,
        input  o_imem_write_enable,
        input  o_imem_address,
        input  o_imem_write_data,
        input  o_imem_read_enable
    );
endinterface

// File: rtl/instruction_loader.sv
// Fills instruction memory from a big-endian byte stream, one 32-bit word per four bytes,
// stopping on the halt word or when the last address has been written.
module instruction_loader #(
    parameter int unsigned         PC_WIDTH   = 9,
    parameter int unsigned         NB_WIDTH   = 32,
    parameter int unsigned         NB_BYTE    = 8,
    parameter logic [NB_WIDTH-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    instruction_loader_if.master  bus,
    output logic                  o_busy,
    output logic                  o_load_done,
    output logic                  o_overflow,
    output logic [PC_WIDTH:0]     o_word_count
);

    localparam int unsigned          SHIFT_W    = NB_WIDTH - NB_BYTE;
    localparam logic [PC_WIDTH-1:0]  LAST_ADDR  = {PC_WIDTH{1'b1}};
    localparam logic [PC_WIDTH:0]    FULL_COUNT = {1'b1, {PC_WIDTH{1'b0}}};
    localparam logic [1:0]           LAST_BYTE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FINISH,
        S_DONE,
        S_ERROR
    } state_e;

    state_e               state_q,      state_d;
    logic [1:0]           byte_cnt_q,   byte_cnt_d;
    logic [SHIFT_W-1:0]   shift_q,      shift_d;
    logic [PC_WIDTH-1:0]  addr_q,       addr_d;
    logic [PC_WIDTH:0]    word_count_q, word_count_d;
    logic [NB_WIDTH-1:0]  wdata_q,      wdata_d;
    logic                 we_q,         we_d;
    logic [NB_WIDTH-1:0]  word;

    assign word = {shift_q, bus.i_rx_data};

    // NOTE: every variable gets its default before the case statement, so no path
    // through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;

        // A write pulse retires at this edge: advance address and count, both saturating.
        if (we_q) begin
            if (addr_q != LAST_ADDR) begin
                addr_d = addr_q + 1'b1;
            end
            if (word_count_q != FULL_COUNT) begin
                word_count_d = word_count_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_d      = S_LOAD;
                    byte_cnt_d   = '0;
                    shift_d      = '0;
                    addr_d       = '0;
                    word_count_d = '0;
                end
            end

            S_LOAD: begin
                if (bus.i_rx_valid) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        wdata_d    = word;
                        we_d       = 1'b1;
                        shift_d    = '0;
                        byte_cnt_d = '0;
                        if (word == HALT_INSTR) begin
                            state_d = S_FINISH;
                        end else if (addr_q == LAST_ADDR) begin
                            state_d = S_ERROR;
                        end
                    end else begin
                        shift_d    = {shift_q[SHIFT_W-NB_BYTE-1:0], bus.i_rx_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            word_count_q <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
        end
    end

    assign bus.o_imem_write_enable = we_q;
    assign bus.o_imem_address      = addr_q;
    assign bus.o_imem_write_data   = wdata_q;
    assign bus.o_imem_read_enable  = ((state_q == S_IDLE) || (state_q == S_DONE)) && !we_q;

    assign o_busy       = (state_q == S_LOAD) || (state_q == S_FINISH);
    assign o_load_done  = (state_q == S_DONE);
    assign o_overflow   = (state_q == S_ERROR);
    assign o_word_count = word_count_q;

endmodule
